// File: rtl/forward_hazard_unit.sv
// Operand-forwarding selects and load-use interlock over a shadow scoreboard of EX..stage N writers.
// fwd_sel/stall_id are combinational from state; state moves only on pipe_advance.
module forward_hazard_unit #(
  parameter int NUM_SRC        = 2,
  parameter int NUM_FWD_STAGES = 2,
  parameter int LOAD_LAT       = 1,
  localparam int SEL_W         = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_advance,
  input  logic                     flush,
  input  logic                     id_valid,
  input  logic [NUM_SRC*5-1:0]     id_rs_addr,
  input  logic [NUM_SRC-1:0]       id_rs_used,
  input  logic [4:0]               id_rd_addr,
  input  logic                     id_rd_we,
  input  logic                     id_is_load,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic                     stall_id,
  output logic [31:0]              stall_count
);

  localparam int N = NUM_FWD_STAGES;

  logic             ent_vld  [0:N];
  logic [4:0]       ent_rd   [0:N];
  logic             ent_we   [0:N];
  logic             ent_ld   [0:N];
  logic [4:0]       ex_rs    [0:NUM_SRC-1];
  logic [NUM_SRC-1:0] ex_used;

  logic             id_load;
  logic [4:0]       chk_rs;
  logic             young_ld;

  assign id_load = id_valid && !stall_id && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= N; k++) begin
        ent_vld[k] <= 1'b0;
        ent_rd[k]  <= 5'd0;
        ent_we[k]  <= 1'b0;
        ent_ld[k]  <= 1'b0;
      end
      for (int i = 0; i < NUM_SRC; i++) ex_rs[i] <= 5'd0;
      ex_used     <= '0;
      stall_count <= 32'd0;
    end else if (pipe_advance) begin
      for (int k = 1; k <= N; k++) begin
        ent_vld[k] <= ent_vld[k-1];
        ent_rd[k]  <= ent_rd[k-1];
        ent_we[k]  <= ent_we[k-1];
        ent_ld[k]  <= ent_ld[k-1];
      end
      // A stalled or squashed ID slot enters EX as a fully cleared bubble.
      ent_vld[0] <= id_load;
      ent_rd[0]  <= id_load ? id_rd_addr : 5'd0;
      ent_we[0]  <= id_load && id_rd_we;
      ent_ld[0]  <= id_load && id_is_load;
      for (int i = 0; i < NUM_SRC; i++)
        ex_rs[i] <= id_load ? id_rs_addr[5*i +: 5] : 5'd0;
      ex_used <= id_load ? id_rs_used : '0;
      if (stall_id && (stall_count != 32'hFFFF_FFFF))
        stall_count <= stall_count + 32'd1;
    end
  end

  // Scan oldest to youngest so the smallest qualifying stage is the last write.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = N; k >= 1; k--) begin
        if (ent_vld[k] && ent_we[k] && (ent_rd[k] == ex_rs[i]) &&
            (ex_rs[i] != 5'd0) && ex_used[i] &&
            !(ent_ld[k] && (k < 1 + LOAD_LAT)))
          fwd_sel[SEL_W*i +: SEL_W] = SEL_W'(k);
      end
    end
  end

  // Only the youngest writer of a register decides; a younger ALU writer masks an older load.
  always_comb begin
    stall_id = 1'b0;
    chk_rs   = 5'd0;
    young_ld = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      chk_rs   = id_rs_addr[5*i +: 5];
      young_ld = 1'b0;
      for (int s = N - 1; s >= 0; s--) begin
        if (ent_vld[s] && ent_we[s] && (ent_rd[s] == chk_rs))
          young_ld = ent_ld[s] && (s < LOAD_LAT);
      end
      if (id_valid && !flush && id_rs_used[i] && (chk_rs != 5'd0) && young_ld)
        stall_id = 1'b1;
    end
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench: default instance plus a LOAD_LAT=2 / 3-stage instance sharing stimulus.
module tb_forward_hazard_unit;

  logic        clk = 1'b0;
  logic        rst, pipe_advance, flush, id_valid;
  logic [9:0]  id_rs_addr;
  logic [1:0]  id_rs_used;
  logic [4:0]  id_rd_addr;
  logic        id_rd_we, id_is_load;
  logic [3:0]  fwd_sel, fwd_sel2;
  logic        stall_id, stall_id2;
  logic [31:0] stall_count, stall_count2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  forward_hazard_unit dut (
    .clk(clk), .rst(rst), .pipe_advance(pipe_advance), .flush(flush),
    .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
    .fwd_sel(fwd_sel), .stall_id(stall_id), .stall_count(stall_count)
  );

  forward_hazard_unit #(.NUM_SRC(2), .NUM_FWD_STAGES(3), .LOAD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .pipe_advance(pipe_advance), .flush(flush),
    .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
    .fwd_sel(fwd_sel2), .stall_id(stall_id2), .stall_count(stall_count2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic id_set(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [1:0] used, input logic [4:0] rd,
                        input logic we, input logic ld);
    id_valid   = v;
    id_rs_addr = {rs2, rs1};
    id_rs_used = used;
    id_rd_addr = rd;
    id_rd_we   = we;
    id_is_load = ld;
  endtask

  task automatic id_idle();
    id_set(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
  endtask

  // Inputs change at posedge+1, checks happen at posedge+2, well clear of the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; pipe_advance = 1'b1; flush = 1'b0;
    id_idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pipe_advance = 1'b1; flush = 1'b0;
    id_idle();

    do_reset();
    #1;
    check("rst_fwd", fwd_sel, 0);
    check("rst_stall", stall_id, 0);
    check("rst_count", stall_count, 0);

    // Two writers of x5 in flight: youngest (EX/MEM) wins.
    id_set(1, 0, 0, 2'b00, 5, 1, 0); tick();
    id_set(1, 0, 0, 2'b00, 5, 1, 0); tick();
    id_set(1, 5, 0, 2'b01, 6, 1, 0); tick();
    #1 check("t1_youngest", fwd_sel, 4'b0001);

    // Only MEM/WB writer remains, both sources read x5.
    do_reset();
    id_set(1, 0, 0, 2'b00, 5, 1, 0); tick();
    id_idle(); tick();
    id_set(1, 5, 5, 2'b11, 6, 1, 0); tick();
    #1 check("t1_memwb", fwd_sel, 4'b1010);

    // Writer with we=0 is ignored.
    do_reset();
    id_set(1, 0, 0, 2'b00, 9, 0, 0); tick();
    id_set(1, 9, 0, 2'b01, 6, 1, 0); tick();
    #1 check("we0_fwd", fwd_sel, 0);

    // Load-use: one stall cycle, then forward from MEM/WB.
    do_reset();
    id_set(1, 0, 0, 2'b00, 3, 1, 1); tick();
    id_set(1, 3, 3, 2'b11, 4, 1, 0);
    #1 check("t2_stall", stall_id, 1);
    tick();
    #1 check("t2_stall_end", stall_id, 0);
    check("t2_count_a", stall_count, 1);
    tick();
    id_idle();
    #1 check("t2_fwd", fwd_sel, 4'b1010);
    check("t2_count_b", stall_count, 1);

    // Freeze holds state and does not count.
    do_reset();
    id_set(1, 0, 0, 2'b00, 3, 1, 1); tick();
    id_set(1, 3, 0, 2'b01, 4, 1, 0);
    pipe_advance = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1 check("t3_frz_stall", stall_id, 1);
      check("t3_frz_count", stall_count, 0);
      tick();
    end
    pipe_advance = 1'b1;
    #1 check("t3_held_stall", stall_id, 1);
    tick();
    #1 check("t3_count", stall_count, 1);

    // Flush suppresses stall (also during freeze) and bubbles EX.
    do_reset();
    id_set(1, 0, 0, 2'b00, 3, 1, 1); tick();
    id_set(1, 3, 0, 2'b01, 4, 1, 0);
    flush = 1'b1; pipe_advance = 1'b0;
    #1 check("t4_frz_flush", stall_id, 0);
    tick();
    pipe_advance = 1'b1;
    #1 check("t4_flush", stall_id, 0);
    tick();
    flush = 1'b0;
    id_idle();
    #1 check("t4_bubble_fwd", fwd_sel, 0);
    check("t4_count", stall_count, 0);
    id_set(1, 3, 0, 2'b01, 4, 1, 0);
    #1 check("t4_no_stall", stall_id, 0);
    tick();
    #1 check("t4_fwd_wb", fwd_sel, 4'b0010);

    // LOAD_LAT=2, 3 stages: two stalls then select 3.
    do_reset();
    id_set(1, 0, 0, 2'b00, 7, 1, 1); tick();
    id_set(1, 7, 0, 2'b01, 8, 1, 0);
    #1 check("t5_stall_a", stall_id2, 1);
    tick();
    #1 check("t5_stall_b", stall_id2, 1);
    tick();
    #1 check("t5_stall_end", stall_id2, 0);
    check("t5_count", stall_count2, 2);
    tick();
    id_idle();
    #1 check("t5_fwd3", fwd_sel2, 4'h3);

    // Load already at stage 1: one stall cycle.
    do_reset();
    id_set(1, 0, 0, 2'b00, 7, 1, 1); tick();
    id_idle(); tick();
    id_set(1, 7, 0, 2'b01, 8, 1, 0);
    #1 check("t5b_stall", stall_id2, 1);
    tick();
    #1 check("t5b_stall_end", stall_id2, 0);
    check("t5b_count", stall_count2, 1);

    // Younger ALU writer masks an older load.
    do_reset();
    id_set(1, 0, 0, 2'b00, 7, 1, 1); tick();
    id_set(1, 0, 0, 2'b00, 7, 1, 0); tick();
    id_set(1, 7, 0, 2'b01, 8, 1, 0);
    #1 check("mask_stall", stall_id2, 0);

    // x0 never forwards or stalls.
    do_reset();
    id_set(1, 0, 0, 2'b00, 0, 1, 1); tick();
    id_set(1, 0, 0, 2'b11, 6, 1, 0);
    #1 check("x0_stall", stall_id, 0);
    tick();
    id_idle();
    #1 check("x0_fwd", fwd_sel, 0);

    // Reset in the middle of a multi-cycle stall.
    do_reset();
    id_set(1, 0, 0, 2'b00, 7, 1, 1); tick();
    id_set(1, 7, 0, 2'b01, 8, 1, 0); tick();
    #1 check("rst_mid_pre", stall_count2, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 check("rst_mid_stall", stall_id2, 0);
    check("rst_mid_count", stall_count2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
